// File: rtl/cache_refill_ctrl_if.sv
// Bundle of CPU, cache-substitution and memory signals seen by the refill controller.
// The master modport is the controller side; slave is the cache/memory/CPU environment.
interface cache_refill_ctrl_if #(
   parameter int ADDR_W  = 30,
   parameter int DATA_W  = 32,
   parameter int INDEX_W = 10
);
   logic [ADDR_W-1:0]         cpu_addr;
   logic                      cpu_rd;
   logic                      cpu_wr;
   logic                      r_miss;
   logic                      w_miss;
   logic                      dirty_bit;
   logic [DATA_W-1:0]         wb_data;
   logic [ADDR_W-INDEX_W-1:0] victim_tag;
   logic                      substitude_fin;
   logic [ADDR_W-1:0]         cache_addr;
   logic                      substitude;
   logic [DATA_W-1:0]         substitude_data;
   logic                      mem_req;
   logic                      mem_we;
   logic [ADDR_W-1:0]         mem_addr;
   logic [DATA_W-1:0]         mem_wdata;
   logic                      mem_ack;
   logic [DATA_W-1:0]         mem_rdata;
   logic                      stall;
   logic                      busy;
   logic                      err;
   logic [15:0]               refill_cnt;
   logic [15:0]               wb_cnt;

   modport master (
      input  cpu_addr, cpu_rd, cpu_wr, r_miss, w_miss, dirty_bit, wb_data, victim_tag,
             substitude_fin, mem_ack, mem_rdata,
      output cache_addr, substitude, substitude_data, mem_req, mem_we, mem_addr, mem_wdata,
             stall, busy, err, refill_cnt, wb_cnt
   );

   modport slave (
      output cpu_addr, cpu_rd, cpu_wr, r_miss, w_miss, dirty_bit, wb_data, victim_tag,
             substitude_fin, mem_ack, mem_rdata,
      input  cache_addr, substitude, substitude_data, mem_req, mem_we, mem_addr, mem_wdata,
             stall, busy, err, refill_cnt, wb_cnt
   );
endinterface

// File: rtl/cache_refill_ctrl.sv
// Miss handler for the 4-way cache: writes back a dirty victim, fetches the missing word,
// hands it to the cache through the substitude handshake and stalls the CPU meanwhile.
module cache_refill_ctrl #(
   parameter int ADDR_W  = 30,
   parameter int DATA_W  = 32,
   parameter int INDEX_W = 10,
   parameter int TIMEOUT = 255
) (
   input logic                clk,
   input logic                rst,
   cache_refill_ctrl_if.master bus
);

   typedef enum logic [2:0] {
      IDLE, CAPTURE, WRITEBACK, FETCH, FILL, WAIT_FIN, RETRY, ERROR
   } state_t;

   localparam logic [8:0] TIMEOUT_LIM = 9'(TIMEOUT);

   state_t            state;
   logic [ADDR_W-1:0] miss_addr;
   logic [7:0]        tcnt;
   logic              fin_pend;
   logic              miss;
   logic              timeout_hit;

   logic              substitude_r;
   logic [DATA_W-1:0] substitude_data_r;
   logic              mem_req_r;
   logic              mem_we_r;
   logic [ADDR_W-1:0] mem_addr_r;
   logic [DATA_W-1:0] mem_wdata_r;
   logic              err_r;
   logic [15:0]       refill_cnt_r;
   logic [15:0]       wb_cnt_r;

   assign miss        = (bus.cpu_rd & bus.r_miss) | (bus.cpu_wr & bus.w_miss);
   assign timeout_hit = (TIMEOUT != 0) && (({1'b0, tcnt} + 9'd1) == TIMEOUT_LIM);

   // RETRY and ERROR release the CPU; RETRY also hands the cache back to cpu_addr so the re-issue hits.
   assign bus.stall      = (state == IDLE) ? miss : !((state == RETRY) || (state == ERROR));
   assign bus.busy       = (state != IDLE);
   assign bus.cache_addr = ((state == IDLE) || (state == RETRY)) ? bus.cpu_addr : miss_addr;

   assign bus.substitude      = substitude_r;
   assign bus.substitude_data = substitude_data_r;
   assign bus.mem_req         = mem_req_r;
   assign bus.mem_we          = mem_we_r;
   assign bus.mem_addr        = mem_addr_r;
   assign bus.mem_wdata       = mem_wdata_r;
   assign bus.err             = err_r;
   assign bus.refill_cnt      = refill_cnt_r;
   assign bus.wb_cnt          = wb_cnt_r;

   // Memory-side outputs are loaded on entry to WRITEBACK/FETCH so they stay stable until ack.
   // Leaving WRITEBACK clears mem_req; FETCH's first cycle then re-raises it, giving the idle gap.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state             <= IDLE;
         miss_addr         <= '0;
         tcnt              <= '0;
         fin_pend          <= 1'b0;
         substitude_r      <= 1'b0;
         substitude_data_r <= '0;
         mem_req_r         <= 1'b0;
         mem_we_r          <= 1'b0;
         mem_addr_r        <= '0;
         mem_wdata_r       <= '0;
         err_r             <= 1'b0;
         refill_cnt_r      <= '0;
         wb_cnt_r          <= '0;
      end else begin
         substitude_r <= 1'b0;
         err_r        <= 1'b0;
         case (state)
            IDLE: begin
               if (miss) begin
                  miss_addr <= bus.cpu_addr;
                  state     <= CAPTURE;
               end
            end
            CAPTURE: begin
               tcnt      <= '0;
               mem_req_r <= 1'b1;
               if (bus.dirty_bit) begin
                  mem_we_r    <= 1'b1;
                  mem_addr_r  <= {bus.victim_tag, miss_addr[INDEX_W-1:0]};
                  mem_wdata_r <= bus.wb_data;
                  state       <= WRITEBACK;
               end else begin
                  mem_we_r   <= 1'b0;
                  mem_addr_r <= miss_addr;
                  state      <= FETCH;
               end
            end
            WRITEBACK: begin
               if (bus.mem_ack) begin
                  mem_req_r  <= 1'b0;
                  mem_we_r   <= 1'b0;
                  mem_addr_r <= miss_addr;
                  if (wb_cnt_r != 16'hFFFF) wb_cnt_r <= wb_cnt_r + 16'd1;
                  state      <= FETCH;
               end else if (timeout_hit) begin
                  mem_req_r <= 1'b0;
                  mem_we_r  <= 1'b0;
                  err_r     <= 1'b1;
                  state     <= ERROR;
               end else begin
                  tcnt <= tcnt + 8'd1;
               end
            end
            FETCH: begin
               if (!mem_req_r) begin
                  mem_req_r <= 1'b1;
                  tcnt      <= '0;
               end else if (bus.mem_ack) begin
                  mem_req_r         <= 1'b0;
                  substitude_data_r <= bus.mem_rdata;
                  substitude_r      <= 1'b1;
                  fin_pend          <= 1'b0;
                  state             <= FILL;
               end else if (timeout_hit) begin
                  mem_req_r <= 1'b0;
                  err_r     <= 1'b1;
                  state     <= ERROR;
               end else begin
                  tcnt <= tcnt + 8'd1;
               end
            end
            FILL: begin
               fin_pend <= bus.substitude_fin;
               state    <= WAIT_FIN;
            end
            WAIT_FIN: begin
               if (bus.substitude_fin || fin_pend) begin
                  fin_pend <= 1'b0;
                  if (refill_cnt_r != 16'hFFFF) refill_cnt_r <= refill_cnt_r + 16'd1;
                  state    <= RETRY;
               end
            end
            RETRY:   state <= IDLE;
            ERROR:   state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_cache_refill_ctrl.sv
// Directed bench for cache_refill_ctrl: a table of complete miss transactions plus
// hand-written sequences for timeout, stray acks and mid-writeback reset.
module tb_cache_refill_ctrl;

   localparam int ADDR_W  = 30;
   localparam int DATA_W  = 32;
   localparam int INDEX_W = 10;

   typedef struct {
      logic [29:0] addr;
      logic        isWrite;
      logic        dirty;
      logic [19:0] vtag;
      logic [31:0] wbData;
      logic [29:0] wbAddr;
      logic [31:0] rdata;
      int          ackDelay;
      int          finDelay;
   } vec_t;

   logic clk;
   logic rst;
   int   nCompared;
   int   nMismatched;
   int   expRefill;
   int   expWb;
   bit   counting;
   int   stallSeen;
   int   subSeen;
   vec_t vecs [5];

   cache_refill_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .INDEX_W(INDEX_W)) bus ();

   cache_refill_ctrl #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .INDEX_W(INDEX_W), .TIMEOUT(8)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation still running, required completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      nCompared++;
      if (actual !== expected) begin
         nMismatched++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   // Samples mid-cycle, then advances to 1 time unit after the next rising edge.
   task automatic tick();
      #3;
      if (counting) begin
         stallSeen += int'(bus.stall);
         subSeen   += int'(bus.substitude);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic dropCpu();
      bus.cpu_rd = 1'b0;
      bus.cpu_wr = 1'b0;
      bus.r_miss = 1'b0;
      bus.w_miss = 1'b0;
   endtask

   // Runs one full miss transaction; expects to be entered one unit after a rising edge in IDLE.
   task automatic applyStimulus(input vec_t v);
      int expStall;
      expStall = 2 + (v.ackDelay + 1) + 1 + ((v.finDelay < 0) ? 1 : v.finDelay + 1);
      if (v.dirty) expStall += (v.ackDelay + 1) + 1;

      bus.cpu_addr = v.addr;
      if (v.isWrite) begin bus.cpu_wr = 1'b1; bus.w_miss = 1'b1; end
      else           begin bus.cpu_rd = 1'b1; bus.r_miss = 1'b1; end
      counting = 1'b1; stallSeen = 0; subSeen = 0;
      #1;
      checkOutput("idle_miss_stall", 32'(bus.stall), 32'd1);
      tick();
      bus.dirty_bit = v.dirty; bus.wb_data = v.wbData; bus.victim_tag = v.vtag;
      checkOutput("capture_busy", 32'(bus.busy), 32'd1);
      checkOutput("capture_cache_addr", 32'(bus.cache_addr), 32'(v.addr));
      tick();
      bus.dirty_bit = 1'b0;
      if (v.dirty) begin
         checkOutput("wb_req", 32'(bus.mem_req), 32'd1);
         checkOutput("wb_we", 32'(bus.mem_we), 32'd1);
         checkOutput("wb_addr", 32'(bus.mem_addr), 32'(v.wbAddr));
         checkOutput("wb_wdata", bus.mem_wdata, v.wbData);
         for (int i = 0; i < v.ackDelay; i++) tick();
         bus.mem_ack = 1'b1;
         tick();
         expWb++;
         checkOutput("wb_gap_req", 32'(bus.mem_req), 32'd0);
         tick();
         bus.mem_ack = 1'b0;
      end
      checkOutput("fetch_req", 32'(bus.mem_req), 32'd1);
      checkOutput("fetch_we", 32'(bus.mem_we), 32'd0);
      checkOutput("fetch_addr", 32'(bus.mem_addr), 32'(v.addr));
      for (int i = 0; i < v.ackDelay; i++) tick();
      bus.mem_rdata = v.rdata; bus.mem_ack = 1'b1;
      tick();
      bus.mem_ack = 1'b0; bus.mem_rdata = '0;
      checkOutput("fill_sub", 32'(bus.substitude), 32'd1);
      checkOutput("fill_data", bus.substitude_data, v.rdata);
      checkOutput("fill_req_low", 32'(bus.mem_req), 32'd0);
      if (v.finDelay < 0) bus.substitude_fin = 1'b1;
      tick();
      bus.substitude_fin = 1'b0;
      bus.cpu_wr = 1'b1; bus.w_miss = 1'b1;
      checkOutput("waitfin_busy", 32'(bus.busy), 32'd1);
      if (v.finDelay >= 0) begin
         for (int i = 0; i < v.finDelay; i++) tick();
         bus.substitude_fin = 1'b1;
         tick();
         bus.substitude_fin = 1'b0;
      end else begin
         tick();
      end
      counting = 1'b0;
      expRefill++;
      checkOutput("retry_stall", 32'(bus.stall), 32'd0);
      checkOutput("retry_busy", 32'(bus.busy), 32'd1);
      checkOutput("stall_cycles", 32'(stallSeen), 32'(expStall));
      checkOutput("sub_pulses", 32'(subSeen), 32'd1);
      dropCpu();
      tick();
      checkOutput("done_busy", 32'(bus.busy), 32'd0);
      checkOutput("refill_cnt", 32'(bus.refill_cnt), 32'(expRefill));
      checkOutput("wb_cnt", 32'(bus.wb_cnt), 32'(expWb));
   endtask

   initial begin
      int n;
      nCompared = 0; nMismatched = 0; expRefill = 0; expWb = 0;
      counting = 1'b0; stallSeen = 0; subSeen = 0;

      vecs[0] = '{addr:30'h0001234, isWrite:1'b0, dirty:1'b0, vtag:20'h0, wbData:32'h0,
                  wbAddr:30'h0, rdata:32'hDEADBEEF, ackDelay:3, finDelay:0};
      vecs[1] = '{addr:30'h0004834, isWrite:1'b0, dirty:1'b1, vtag:20'h00ABC, wbData:32'h11112222,
                  wbAddr:30'h02AF034, rdata:32'h55AA00FF, ackDelay:1, finDelay:0};
      vecs[2] = '{addr:30'h1555AAA, isWrite:1'b1, dirty:1'b0, vtag:20'h0, wbData:32'h0,
                  wbAddr:30'h0, rdata:32'hCAFEF00D, ackDelay:0, finDelay:4};
      vecs[3] = '{addr:30'h0000000, isWrite:1'b0, dirty:1'b0, vtag:20'h0, wbData:32'h0,
                  wbAddr:30'h0, rdata:32'h00000001, ackDelay:0, finDelay:-1};
      vecs[4] = '{addr:30'h3FFFFFFF, isWrite:1'b1, dirty:1'b1, vtag:20'h80001, wbData:32'hA5A5A5A5,
                  wbAddr:30'h200007FF, rdata:32'hFFFFFFFF, ackDelay:2, finDelay:1};

      rst = 1'b1;
      bus.cpu_addr = 30'h2AAAAAAA;
      dropCpu();
      bus.dirty_bit = 1'b0; bus.wb_data = '0; bus.victim_tag = '0;
      bus.substitude_fin = 1'b0; bus.mem_ack = 1'b0; bus.mem_rdata = '0;
      repeat (2) @(posedge clk);
      #1;
      checkOutput("reset_req", 32'(bus.mem_req), 32'd0);
      checkOutput("reset_sub", 32'(bus.substitude), 32'd0);
      checkOutput("reset_stall", 32'(bus.stall), 32'd0);
      checkOutput("reset_busy", 32'(bus.busy), 32'd0);
      checkOutput("reset_err", 32'(bus.err), 32'd0);
      checkOutput("reset_refill", 32'(bus.refill_cnt), 32'd0);
      checkOutput("reset_wb", 32'(bus.wb_cnt), 32'd0);
      checkOutput("reset_cache_addr", 32'(bus.cache_addr), 32'h2AAAAAAA);
      rst = 1'b0;
      tick();

      for (int i = 0; i < 5; i++) applyStimulus(vecs[i]);

      // Stray ack in IDLE must not start anything.
      bus.mem_ack = 1'b1;
      tick();
      bus.mem_ack = 1'b0;
      checkOutput("stray_ack_busy", 32'(bus.busy), 32'd0);
      checkOutput("stray_ack_req", 32'(bus.mem_req), 32'd0);
      tick();
      checkOutput("stray_ack_busy2", 32'(bus.busy), 32'd0);

      // Memory never answers: timeout of 8 cycles.
      bus.cpu_addr = 30'h0000100; bus.cpu_rd = 1'b1; bus.r_miss = 1'b1;
      tick();
      tick();
      n = 0;
      while (bus.mem_req && n < 20) begin
         n++;
         tick();
      end
      checkOutput("timeout_req_cycles", 32'(n), 32'd8);
      checkOutput("timeout_err", 32'(bus.err), 32'd1);
      checkOutput("timeout_stall", 32'(bus.stall), 32'd0);
      dropCpu();
      tick();
      checkOutput("timeout_err_pulse", 32'(bus.err), 32'd0);
      checkOutput("timeout_idle", 32'(bus.busy), 32'd0);
      checkOutput("timeout_refill", 32'(bus.refill_cnt), 32'(expRefill));
      checkOutput("timeout_wb", 32'(bus.wb_cnt), 32'(expWb));

      // Asynchronous reset while a write-back is outstanding.
      bus.cpu_addr = vecs[1].addr; bus.cpu_rd = 1'b1; bus.r_miss = 1'b1;
      tick();
      bus.dirty_bit = 1'b1; bus.victim_tag = vecs[1].vtag; bus.wb_data = vecs[1].wbData;
      tick();
      bus.dirty_bit = 1'b0;
      dropCpu();
      checkOutput("pre_reset_wb_req", 32'(bus.mem_req), 32'd1);
      #1 rst = 1'b1;
      #1;
      checkOutput("async_reset_req", 32'(bus.mem_req), 32'd0);
      checkOutput("async_reset_busy", 32'(bus.busy), 32'd0);
      checkOutput("async_reset_refill", 32'(bus.refill_cnt), 32'd0);
      checkOutput("async_reset_wb", 32'(bus.wb_cnt), 32'd0);
      rst = 1'b0;
      expRefill = 0; expWb = 0;
      tick();
      applyStimulus(vecs[1]);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

endmodule
